// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: widths, NOP encoding
// and the fetch-stage state encoding.
package mips_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush loads a NOP bubble,
// load captures a fetched word, otherwise contents hold.
module ifid_reg
    import mips_pkg::*;
#(
    parameter int                 P_PC_W    = mips_pkg::PC_W,
    parameter int                 P_INSTR_W = mips_pkg::INSTR_W,
    parameter logic [P_INSTR_W-1:0] P_NOP   = mips_pkg::NOP_WORD
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 load,
    input  logic [P_PC_W-1:0]    pc_in,
    input  logic [P_INSTR_W-1:0] instr_in,
    output logic [P_PC_W-1:0]    pc,
    output logic [P_INSTR_W-1:0] instr,
    output logic                 valid
);

    // Flush wins over load; neither asserted means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= '0;
            instr <= P_NOP;
            valid <= 1'b0;
        end else if (flush) begin
            instr <= P_NOP;
            valid <= 1'b0;
        end else if (load) begin
            pc    <= pc_in;
            instr <= instr_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection,
// boot/run/halt sequencing and the IF/ID register.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int                 PC_W     = mips_pkg::PC_W,
    parameter int                 INSTR_W  = mips_pkg::INSTR_W,
    parameter logic [PC_W-1:0]    RESET_PC = '0,
    parameter logic [INSTR_W-1:0] NOP_WORD = mips_pkg::NOP_WORD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               branch_taken_i,
    input  logic [PC_W-1:0]    branch_target_i,
    input  logic               jump_i,
    input  logic [PC_W-1:0]    jump_target_i,
    input  logic               halt_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    output logic [PC_W-1:0]    ifid_pc_o,
    output logic [INSTR_W-1:0] ifid_instr_o,
    output logic               ifid_valid_o,
    output logic               halted_o
);

    fetch_state_t    state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;
    logic            running;
    logic            redirect;
    logic            halt_go;
    logic            flush;
    logic            load;

    assign imem_addr_o = pc;
    assign pc_inc      = pc + PC_W'(1);

    // Decode this cycle's action; branch is older than jump,
    // and a redirect squashes a (wrong-path) halt.
    always_comb begin
        running  = (state == RUN);
        redirect = running && (branch_taken_i || jump_i);
        target   = branch_taken_i ? branch_target_i : jump_target_i;
        halt_go  = running && !redirect && !stall_i && halt_i;
        flush    = redirect || halt_go;
        load     = running && !redirect && !stall_i && !halt_i;
    end

    // PC register and fetch sequencing FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= BOOT;
            halted_o <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (halt_go) begin
                        state    <= HALTED;
                        halted_o <= 1'b1;
                    end else if (load) begin
                        pc <= pc_inc;
                    end
                end
                HALTED: begin
                    halted_o <= 1'b1;
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

    ifid_reg #(
        .P_PC_W    (PC_W),
        .P_INSTR_W (INSTR_W),
        .P_NOP     (NOP_WORD)
    ) u_ifid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .load     (load),
        .pc_in    (pc_inc),
        .instr_in (imem_rdata_i),
        .pc       (ifid_pc_o),
        .instr    (ifid_instr_o),
        .valid    (ifid_valid_o)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios
// plus randomized traffic against a cycle-level model.
module tb_pc_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = 32'h0;

    logic               clk;
    logic               rst_n;
    logic               stall;
    logic               br;
    logic [PC_W-1:0]    bt;
    logic               jmp;
    logic [PC_W-1:0]    jt;
    logic               halt;
    logic [PC_W-1:0]    addr;
    logic [INSTR_W-1:0] rdata;
    logic [PC_W-1:0]    ipc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
    logic               halted;

    logic [INSTR_W-1:0] rom [1024];

    int n_checks = 0;
    int n_fail   = 0;

    assign rdata = rom[addr];

    pc_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .branch_taken_i  (br),
        .branch_target_i (bt),
        .jump_i          (jmp),
        .jump_target_i   (jt),
        .halt_i          (halt),
        .imem_addr_o     (addr),
        .imem_rdata_i    (rdata),
        .ifid_pc_o       (ipc),
        .ifid_instr_o    (instr),
        .ifid_valid_o    (valid),
        .halted_o        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic b,
                         input int btv, input logic j,
                         input int jtv, input logic h);
        stall = s;
        br    = b;
        bt    = PC_W'(btv);
        jmp   = j;
        jt    = PC_W'(jtv);
        halt  = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rom[0] = 32'h1111_1111;
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks += 4;
        if (addr !== 10'd0) begin
            $display("FAIL rst_addr got=%0d exp=0", addr); n_fail++;
        end
        if (valid !== 1'b0) begin
            $display("FAIL rst_valid got=%0b exp=0", valid); n_fail++;
        end
        if (instr !== NOP || ipc !== 10'd0) begin
            $display("FAIL rst_ifid got=%h/%0d exp=%h/0", instr, ipc, NOP);
            n_fail++;
        end
        if (halted !== 1'b0) begin
            $display("FAIL rst_halted got=%0b exp=0", halted); n_fail++;
        end
        rst_n = 1'b1;
        tick();
        n_checks += 2;
        if (valid !== 1'b0) begin
            $display("FAIL boot_valid got=%0b exp=0", valid); n_fail++;
        end
        if (addr !== 10'd0) begin
            $display("FAIL boot_addr got=%0d exp=0", addr); n_fail++;
        end
        tick();
        n_checks += 4;
        if (instr !== 32'h1111_1111) begin
            $display("FAIL first_instr got=%h exp=11111111", instr); n_fail++;
        end
        if (ipc !== 10'd1) begin
            $display("FAIL first_pc got=%0d exp=1", ipc); n_fail++;
        end
        if (valid !== 1'b1) begin
            $display("FAIL first_valid got=%0b exp=1", valid); n_fail++;
        end
        if (addr !== 10'd1) begin
            $display("FAIL first_addr got=%0d exp=1", addr); n_fail++;
        end
    endtask

    task automatic test_stall();
        repeat (4) tick();
        n_checks++;
        if (addr !== 10'd5) begin
            $display("FAIL seq_addr got=%0d exp=5", addr); n_fail++;
        end
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks += 2;
            if (addr !== 10'd5) begin
                $display("FAIL stall_addr got=%0d exp=5", addr); n_fail++;
            end
            if (ipc !== 10'd5 || instr !== rom[4] || valid !== 1'b1) begin
                $display("FAIL stall_ifid got=%0d/%h/%0b exp=5/%h/1",
                         ipc, instr, valid, rom[4]);
                n_fail++;
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_checks += 2;
        if (ipc !== 10'd6) begin
            $display("FAIL unstall_pc got=%0d exp=6", ipc); n_fail++;
        end
        if (instr !== rom[5]) begin
            $display("FAIL unstall_instr got=%h exp=%h", instr, rom[5]);
            n_fail++;
        end
    endtask

    task automatic test_branch_stall();
        drive(0, 0, 0, 1, 20, 0);
        tick();
        drive(1, 1, 14, 0, 0, 0);
        tick();
        n_checks += 2;
        if (addr !== 10'd14) begin
            $display("FAIL brstall_addr got=%0d exp=14", addr); n_fail++;
        end
        if (valid !== 1'b0 || instr !== NOP) begin
            $display("FAIL brstall_flush got=%0b/%h exp=0/%h",
                     valid, instr, NOP);
            n_fail++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_checks += 2;
        if (ipc !== 10'd15 || valid !== 1'b1) begin
            $display("FAIL brstall_next got=%0d/%0b exp=15/1", ipc, valid);
            n_fail++;
        end
        if (instr !== rom[14]) begin
            $display("FAIL brstall_instr got=%h exp=%h", instr, rom[14]);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 100, 1, 300, 1);
        tick();
        n_checks += 3;
        if (addr !== 10'd100) begin
            $display("FAIL prio_addr got=%0d exp=100", addr); n_fail++;
        end
        if (halted !== 1'b0) begin
            $display("FAIL prio_halted got=%0b exp=0", halted); n_fail++;
        end
        if (valid !== 1'b0) begin
            $display("FAIL prio_valid got=%0b exp=0", valid); n_fail++;
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_checks++;
        if (ipc !== 10'd101 || valid !== 1'b1) begin
            $display("FAIL prio_run got=%0d/%0b exp=101/1", ipc, valid);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        drive(0, 0, 0, 1, 1023, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        n_checks += 3;
        if (ipc !== 10'd0 || addr !== 10'd0) begin
            $display("FAIL wrap_pc got=%0d/%0d exp=0/0", ipc, addr);
            n_fail++;
        end
        if (valid !== 1'b1) begin
            $display("FAIL wrap_valid got=%0b exp=1", valid); n_fail++;
        end
        if (instr !== rom[1023]) begin
            $display("FAIL wrap_instr got=%h exp=%h", instr, rom[1023]);
            n_fail++;
        end
    endtask

    task automatic test_halt();
        drive(0, 0, 0, 1, 40, 0);
        tick();
        drive(1, 0, 0, 0, 0, 1);
        tick();
        n_checks++;
        if (halted !== 1'b0 || addr !== 10'd40) begin
            $display("FAIL halt_defer got=%0b/%0d exp=0/40", halted, addr);
            n_fail++;
        end
        drive(0, 0, 0, 0, 0, 1);
        tick();
        n_checks += 2;
        if (halted !== 1'b1 || addr !== 10'd40) begin
            $display("FAIL halt_enter got=%0b/%0d exp=1/40", halted, addr);
            n_fail++;
        end
        if (valid !== 1'b0) begin
            $display("FAIL halt_valid got=%0b exp=0", valid); n_fail++;
        end
        drive(0, 1, 7, 0, 0, 0);
        repeat (2) tick();
        n_checks++;
        if (addr !== 10'd40 || halted !== 1'b1 || valid !== 1'b0) begin
            $display("FAIL halt_ignore got=%0d/%0b/%0b exp=40/1/0",
                     addr, halted, valid);
            n_fail++;
        end
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (addr !== 10'd0 || halted !== 1'b0) begin
            $display("FAIL async_rst got=%0d/%0b exp=0/0", addr, halted);
            n_fail++;
        end
        if (valid !== 1'b0 || instr !== NOP || ipc !== 10'd0) begin
            $display("FAIL async_rst_ifid got=%0b/%h/%0d exp=0/%h/0",
                     valid, instr, ipc, NOP);
            n_fail++;
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [PC_W-1:0]    m_pc;
        logic [PC_W-1:0]    m_ipc;
        logic [INSTR_W-1:0] m_instr;
        logic               m_valid;
        logic               m_halted;
        bit                 m_booted;
        int                 halt_age;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0;
        m_halted = 0; m_booted = 0; halt_age = 0;

        for (int cyc = 0; cyc < 800; cyc++) begin
            if (m_halted && halt_age > 4) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0;
                m_halted = 0; m_booted = 0; halt_age = 0;
            end
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1023),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 1023),
                  $urandom_range(0, 39) == 0);

            if (!m_booted) begin
                m_booted = 1;
            end else if (m_halted) begin
                halt_age++;
            end else if (br) begin
                m_pc = bt; m_valid = 0; m_instr = NOP;
            end else if (jmp) begin
                m_pc = jt; m_valid = 0; m_instr = NOP;
            end else if (stall) begin
                m_pc = m_pc;
            end else if (halt) begin
                m_valid = 0; m_instr = NOP; m_halted = 1;
            end else begin
                m_instr = rom[m_pc];
                m_ipc   = PC_W'((int'(m_pc) + 1) % 1024);
                m_valid = 1;
                m_pc    = m_ipc;
            end

            tick();
            n_checks += 5;
            if (addr !== m_pc) begin
                $display("FAIL rnd_addr cyc=%0d got=%0d exp=%0d",
                         cyc, addr, m_pc);
                n_fail++;
            end
            if (ipc !== m_ipc) begin
                $display("FAIL rnd_ifid_pc cyc=%0d got=%0d exp=%0d",
                         cyc, ipc, m_ipc);
                n_fail++;
            end
            if (instr !== m_instr) begin
                $display("FAIL rnd_instr cyc=%0d got=%h exp=%h",
                         cyc, instr, m_instr);
                n_fail++;
            end
            if (valid !== m_valid) begin
                $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b",
                         cyc, valid, m_valid);
                n_fail++;
            end
            if (halted !== m_halted) begin
                $display("FAIL rnd_halted cyc=%0d got=%0b exp=%0b",
                         cyc, halted, m_halted);
                n_fail++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        test_reset();
        test_stall();
        test_branch_stall();
        test_priority();
        test_wrap();
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
